ws2812b_rx: RTL and testbench
=============================

// Module: ws2812b_rx
// PURPOSE
//  Receive side of the WS2812B one-wire LED protocol. Decodes a serial WS2812B stream (the waveform our
//  ws2812b driver emits on _48b) into 24-bit GRB pixel words. Tags each pixel with its index in the frame
//  and flags the >50 us low latch gap as end of frame. Used for driver loopback checks and chained boards.
// PARAMETERS
//  THRESH_CYC    7    high-pulse length (clk cycles) at or above which a bit decodes as 1 (T0H~5, T1H~10 @12MHz)
//  MIN_HIGH_CYC  2    high pulses shorter than this are glitches -> protocol error
//  MAX_HIGH_CYC  14   high pulses longer than this -> protocol error
//  LATCH_CYC     600  consecutive low samples that constitute the latch/reset gap (50 us @12MHz)
//  NUM_PIXELS    64   pixels per frame accepted; later pixels are dropped
//  IDX_W         6    width of pixel index, $clog2(NUM_PIXELS)
// PORTS
//  clk           in   1      system clock (12 MHz)
//  reset_n       in   1      asynchronous active-low reset
//  din           in   1      raw WS2812B serial input, asynchronous to clk
//  pixel_valid   out  1      1-cycle pulse: pixel_data/pixel_index hold a completed pixel
//  pixel_data    out  24     received word, GRB order, first bit received = bit 23
//  pixel_index   out  IDX_W  position of pixel_data within current frame (0 = first)
//  frame_done    out  1      1-cycle pulse at latch gap closing a frame
//  frame_pixels  out  IDX_W+1  complete in-range pixels in the frame just closed; valid while frame_done=1
//  error         out  1      1-cycle pulse on any protocol error
//  busy          out  1      high from first rising edge of a frame until its frame_done/error
// BEHAVIOUR
//  - Reset (async): all outputs 0, counters 0, state SYNC. Takes effect immediately, mid-pixel included;
//    partial data discarded.
//  - din passes a 2-FF synchronizer -> din_s; edges detected on din_s vs its 1-cycle-delayed copy.
//  - FSM states:
//    SYNC: ignore pulses, count low samples; any high restarts count; LATCH_CYC lows -> IDLE, no frame_done.
//    IDLE: line low, frame boundary; low counter saturates at LATCH_CYC; rising edge -> HIGH, busy=1.
//    HIGH: count high cycles (saturating at MAX_HIGH_CYC+1). Count > MAX_HIGH_CYC -> error, go to SYNC.
//      Falling edge: count < MIN_HIGH_CYC -> error, SYNC; else shift bit (count>=THRESH_CYC) into LSB of shreg,
//      bit_cnt++; go to LOW.
//    LOW: count low cycles. Rising edge -> HIGH. Count reaches LATCH_CYC -> latch (below), go IDLE.
//  - Pixel complete: on the falling edge that delivers bit 24, next cycle pixel_valid=1, pixel_data=shreg,
//    pixel_index=pix_cnt; bit_cnt wraps to 0; pix_cnt++.
//  - Latency: din to din_s 2 cycles; pixel_valid exactly 1 cycle after first din_s low of 24th bit.
//  - pix_cnt == NUM_PIXELS when a pixel completes: no pixel_valid, one error pulse per frame, pix_cnt saturates.
//  - Latch: frame_done=1 for 1 cycle, frame_pixels=pix_cnt, pix_cnt=0, busy=0.
//    If bit_cnt!=0 the partial pixel is dropped and error pulses in the same cycle.
//  - Latch and new-frame rising edge cannot coincide: latch needs LATCH_CYC lows; the next sample starts bit 0.
//  - pixel_data/pixel_index/frame_pixels hold last value between pulses. error never coincides with pixel_valid.
//  - Widths: low counter $clog2(LATCH_CYC+1) bits, high counter $clog2(MAX_HIGH_CYC+2), bit_cnt 5 bits,
//    all saturating, no wrap.
// STRUCTURE
//  - ws2812b_pkg: state enum (SYNC, IDLE, HIGH, LOW), 12 MHz T0H/T1H/period/latch cycle constants,
//    GRB colour constants OFF/RED/GREEN/BLUE shared with the transmit path.
//  - Sub-module input_sync: 2-FF synchronizer + rise/fall pulse outputs.
//  - FSM, counters, shift register and output registers live in ws2812b_rx.
// TESTING
//  1. Release reset, drive 10-cycle highs before any 600-cycle low gap -> no pixel_valid, no frame_done
//     (SYNC discards).
//  2. After sync, send 24'hFF0000 (1 = 10 high/5 low, 0 = 5 high/10 low), then 600 lows -> one pixel_valid
//     data FF0000 idx 0; frame_done with frame_pixels=1.
//  3. Loop back existing ws2812b driver + controller, 64-pixel glider frame
//     -> 64 pixel_valid, idx 0..63 in order, data matches sent GRB words, frame_pixels=64.
//  4. Mid-pixel 20-cycle high -> single error pulse, no pixel_valid; resumes only after 600-cycle low gap.
//  5. 12 bits then 600 lows -> error and frame_done same cycle, frame_pixels=0; 1-cycle high -> error (glitch).
//  6. 65 pixels -> 64 pixel_valid, one error, frame_pixels=64; reset_n low mid-bit -> all outputs 0 immediately.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver states, 12 MHz
// timing constants and GRB colour words.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

  localparam int unsigned CLK_HZ    = 12_000_000;
  localparam int unsigned T0H_CYC   = 5;
  localparam int unsigned T0L_CYC   = 10;
  localparam int unsigned T1H_CYC   = 10;
  localparam int unsigned T1L_CYC   = 5;
  localparam int unsigned BIT_CYC   = 15;
  localparam int unsigned LATCH_CYC = 600;

  localparam logic [23:0] GRB_OFF   = 24'h000000;
  localparam logic [23:0] GRB_RED   = 24'h00FF00;
  localparam logic [23:0] GRB_GREEN = 24'hFF0000;
  localparam logic [23:0] GRB_BLUE  = 24'h0000FF;

  function automatic logic [23:0] grb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812b_rx_input_sync.sv
// Two-flop synchronizer for the serial line with
// single-cycle rise/fall strobes on the synced copy.
module ws2812b_rx_input_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic din_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B stream receiver: decodes pulse widths into
// 24-bit GRB pixels, indexes them and detects the latch gap.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int unsigned THRESH_CYC   = 7,
  parameter int unsigned MIN_HIGH_CYC = 2,
  parameter int unsigned MAX_HIGH_CYC = 14,
  parameter int unsigned LATCH_CYC    = 600,
  parameter int unsigned NUM_PIXELS   = 64,
  parameter int unsigned IDX_W        = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               din,
  output logic               pixel_valid,
  output logic [23:0]        pixel_data,
  output logic [IDX_W-1:0]   pixel_index,
  output logic               frame_done,
  output logic [IDX_W:0]     frame_pixels,
  output logic               error,
  output logic               busy
);

  localparam int LW = $clog2(LATCH_CYC + 1);
  localparam int HW = $clog2(MAX_HIGH_CYC + 2);
  localparam int PW = IDX_W + 1;

  localparam logic [LW-1:0] L_MAX  = LW'(LATCH_CYC);
  localparam logic [LW-1:0] L_LAST = LW'(LATCH_CYC - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH_CYC);
  localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] H_THR  = HW'(THRESH_CYC);
  localparam logic [PW-1:0] P_MAX  = PW'(NUM_PIXELS);
  localparam logic [4:0]    B_LAST = 5'd23;

  logic din_s;
  logic rise;
  logic fall;

  rx_state_t state;
  rx_state_t state_nxt;

  logic [LW-1:0] lcnt;
  logic [HW-1:0] hcnt;
  logic [4:0]    bit_cnt;
  logic [22:0]   shreg;
  logic [PW-1:0] pix_cnt;
  logic          ovf_seen;

  logic sync_done;
  logic start;
  logic hi_long;
  logic hi_glitch;
  logic bit_ok;
  logic latch;
  logic bit_val;
  logic proto_err;
  logic pix_done;
  logic pix_keep;
  logic pix_drop;

  ws2812b_rx_input_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .din_s   (din_s),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC: if (sync_done) state_nxt = IDLE;
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (proto_err) state_nxt = SYNC;
        else if (fall) state_nxt = LOW;
      end
      LOW: begin
        if (rise)       state_nxt = HIGH;
        else if (latch) state_nxt = IDLE;
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    sync_done = 1'b0;
    start     = 1'b0;
    hi_long   = 1'b0;
    hi_glitch = 1'b0;
    bit_ok    = 1'b0;
    latch     = 1'b0;
    unique case (state)
      SYNC: sync_done = !din_s && lcnt >= L_LAST;
      IDLE: start = rise;
      HIGH: begin
        hi_long   = hcnt > H_MAX;
        hi_glitch = !hi_long && fall && hcnt < H_MIN;
        bit_ok    = !hi_long && fall && hcnt >= H_MIN;
      end
      LOW: begin
        start = rise;
        latch = !din_s && lcnt >= L_LAST;
      end
      default: ;
    endcase
  end

  assign bit_val   = hcnt >= H_THR;
  assign proto_err = hi_long | hi_glitch;
  assign pix_done  = bit_ok && bit_cnt == B_LAST;
  assign pix_keep  = pix_done && pix_cnt != P_MAX;
  assign pix_drop  = pix_done && pix_cnt == P_MAX;

  // Pulse widths: high count restarts on every rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (start) begin
      hcnt <= HW'(1);
    end else if (state == HIGH && din_s && hcnt <= H_MAX) begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcnt <= '0;
    end else if (proto_err || start) begin
      lcnt <= '0;
    end else if (bit_ok) begin
      lcnt <= LW'(1);
    end else if (state == SYNC && din_s) begin
      lcnt <= '0;
    end else if (state != HIGH && !din_s && lcnt != L_MAX) begin
      lcnt <= lcnt + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      ovf_seen <= 1'b0;
    end else if (proto_err || latch) begin
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      ovf_seen <= 1'b0;
    end else if (bit_ok) begin
      shreg   <= {shreg[21:0], bit_val};
      bit_cnt <= pix_done ? 5'd0 : bit_cnt + 5'd1;
      if (pix_keep) pix_cnt <= pix_cnt + PW'(1);
      if (pix_drop) ovf_seen <= 1'b1;
    end
  end

  // Overflowing pixels report a single error per frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      error        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pixel_valid <= pix_keep;
      frame_done  <= latch;
      error       <= proto_err
                   | (latch && bit_cnt != 5'd0)
                   | (pix_drop && !ovf_seen);
      if (pix_keep) begin
        pixel_data  <= {shreg, bit_val};
        pixel_index <= pix_cnt[IDX_W-1:0];
      end
      if (latch) frame_pixels <= pix_cnt;
      if (state == IDLE && rise)  busy <= 1'b1;
      else if (latch || proto_err) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: frame table plus
// hand-written sync, latency, error and reset sequences.
module tb_ws2812b_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        din;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [5:0]  pixel_index;
  logic        frame_done;
  logic [6:0]  frame_pixels;
  logic        error;
  logic        busy;

  always #5 clk = ~clk;

  ws2812b_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .pixel_index  (pixel_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .error        (error),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  int pv_n = 0;
  int fd_n = 0;
  int err_n = 0;
  int both_n = 0;
  int fd_pix = 0;
  int fd_err = 0;
  logic [23:0] pv_d[$];
  int          pv_i[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (pixel_valid) begin
        pv_d.push_back(pixel_data);
        pv_i.push_back(int'(pixel_index));
        pv_n++;
      end
      if (frame_done) begin
        fd_n++;
        fd_pix = int'(frame_pixels);
        fd_err = int'(error);
      end
      if (error) err_n++;
      if (error && pixel_valid) both_n++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    repeat (b ? 10 : 5) @(negedge clk);
    din = 1'b0;
    repeat (b ? 5 : 10) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[23-i]);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [23:0] px(input logic [23:0] base, input int i);
    logic [7:0] b;
    b = 8'(i);
    return base ^ {b, 8'(b * 3), 8'(b * 5)};
  endfunction

  typedef struct {
    string       name;
    logic [23:0] base;
    int          npix;
    int          xbits;
    int          e_pv;
    int          e_err;
    int          e_fpix;
    int          e_fderr;
  } vec_t;

  vec_t tbl[6];

  int pv0, err0, fd0, bad, lat, lim;

  initial begin
    tbl[0] = '{"one_ff0000",  24'hFF0000,  1,  0,  1, 0,  1, 0};
    tbl[1] = '{"three_pix",   24'h00FF00,  3,  0,  3, 0,  3, 0};
    tbl[2] = '{"glider64",    24'h0000FF, 64,  0, 64, 0, 64, 0};
    tbl[3] = '{"overflow65",  24'h5A3C96, 65,  0, 64, 1, 64, 0};
    tbl[4] = '{"partial12",   24'h000000,  0, 12,  0, 1,  0, 1};
    tbl[5] = '{"two_plus5",   24'hC0FFEE,  2,  5,  2, 1,  2, 1};

    reset_n = 1'b0;
    din     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          int'({pixel_valid, pixel_data, pixel_index, frame_done,
                frame_pixels, error, busy} != '0), 0);

    // Pulses before any latch gap must be discarded
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) send_bit(1'b1);
    gap(650);
    check("sync_pv", pv_n, 0);
    check("sync_fd", fd_n, 0);
    check("sync_err", err_n, 0);

    for (int t = 0; t < 6; t++) begin
      pv0 = pv_n; err0 = err_n; fd0 = fd_n; bad = 0;
      for (int p = 0; p < tbl[t].npix; p++)
        send_word(px(tbl[t].base, p), 24);
      if (tbl[t].xbits > 0) send_word(24'hA5A5A5, tbl[t].xbits);
      gap(650);
      check({tbl[t].name, "_pv"}, pv_n - pv0, tbl[t].e_pv);
      lim = (pv_n - pv0 < tbl[t].e_pv) ? pv_n - pv0 : tbl[t].e_pv;
      for (int k = 0; k < lim; k++) begin
        if (pv_d[pv0+k] !== px(tbl[t].base, k) || pv_i[pv0+k] != k) begin
          if (bad == 0)
            $display("FAIL %s_pix%0d: got %h idx %0d expected %h idx %0d",
                     tbl[t].name, k, pv_d[pv0+k], pv_i[pv0+k],
                     px(tbl[t].base, k), k);
          bad++;
        end
      end
      check({tbl[t].name, "_data"}, bad, 0);
      check({tbl[t].name, "_err"}, err_n - err0, tbl[t].e_err);
      check({tbl[t].name, "_fd"}, fd_n - fd0, 1);
      check({tbl[t].name, "_fpix"}, fd_pix, tbl[t].e_fpix);
      check({tbl[t].name, "_fderr"}, fd_err, tbl[t].e_fderr);
      check({tbl[t].name, "_busy"}, int'(busy), 0);
    end

    // Latency: pixel_valid three negedges after din drops on bit 24
    pv0 = pv_n;
    send_word(24'h0000FF, 23);
    check("busy_mid", int'(busy), 1);
    din = 1'b1;
    repeat (10) @(negedge clk);
    din = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pixel_valid && lat == 0) lat = i;
    end
    check("latency", lat, 3);
    check("lat_data", int'(pixel_data), 32'h0000FF);
    gap(650);
    check("lat_fpix", fd_pix, 1);

    // Over-long high mid-pixel: one error, no pixel, resync required
    pv0 = pv_n; err0 = err_n; fd0 = fd_n;
    send_word(24'hF00000, 5);
    din = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    repeat (10) @(negedge clk);
    send_word(24'hFFFFFF, 24);
    gap(650);
    check("long_err", err_n - err0, 1);
    check("long_pv", pv_n - pv0, 0);
    check("long_fd", fd_n - fd0, 0);
    pv0 = pv_n;
    send_word(24'h123456, 24);
    gap(650);
    check("resume_pv", pv_n - pv0, 1);
    check("resume_data", int'(pixel_data), 32'h123456);

    // One-cycle glitch high
    err0 = err_n; fd0 = fd_n;
    din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_err", err_n - err0, 1);
    gap(650);
    check("glitch_fd", fd_n - fd0, 0);

    // Asynchronous reset in the middle of a high pulse
    send_word(24'hE00000, 3);
    din = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async",
          int'({pixel_valid, pixel_data, pixel_index, frame_done,
                frame_pixels, error, busy} != '0), 0);
    din = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    gap(650);
    pv0 = pv_n; fd0 = fd_n;
    send_word(24'h0F0F0F, 24);
    gap(650);
    check("post_rst_pv", pv_n - pv0, 1);
    check("post_rst_idx", pv_i[pv0], 0);
    check("post_rst_fpix", fd_pix, 1);

    check("err_with_pv", both_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
